// File: rtl/wic_pkg.sv
// Shared definitions for the wakeup interrupt controller / IRQ aggregator.
package wic_pkg;

    // Legal and default number of interrupt sources.
    localparam int unsigned WIC_NUM_SRC_DEF = 32;
    localparam int unsigned WIC_NUM_SRC_MIN = 2;
    localparam int unsigned WIC_NUM_SRC_MAX = 64;

    // Wakeup handshake states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SLEEP    = 2'd1,
        ST_WAKE     = 2'd2,
        ST_WAIT_RUN = 2'd3
    } wic_state_e;

endpackage

// File: rtl/wic_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request bit is
// set and the index of the lowest one.
module wic_prio_enc
    import wic_pkg::*;
#(
    parameter int unsigned N  = WIC_NUM_SRC_DEF,
    parameter int unsigned IW = $clog2(WIC_NUM_SRC_DEF)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan upward and keep the first hit so the lowest index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wic_irq_aggr.sv
// Interrupt aggregator with wakeup handshake: per-source edge/level pending
// tracking, a valid/ready claim port presenting the lowest pending id, and a
// sleep/wake FSM requesting a PMU wakeup while the CPU sleeps.
module wic_irq_aggr
    import wic_pkg::*;
#(
    parameter int unsigned NUM_SRC = WIC_NUM_SRC_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic               pad_core_clk,
    input  logic               pad_core_rst_b,
    input  logic [NUM_SRC-1:0] src_intr,
    input  logic [NUM_SRC-1:0] cfg_en,
    input  logic [NUM_SRC-1:0] cfg_edge,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ready,
    input  logic               cpu_pmu_sleep_b,
    output logic               wic_pmu_wakeup_req,
    input  logic               pmu_wic_wakeup_ack,
    output logic [NUM_SRC-1:0] pend
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] claim_hot;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] cand;
    logic               claim;
    logic               cand_found;
    logic [ID_W-1:0]    cand_id;
    wic_state_e         state_q;
    wic_state_e         state_d;
    logic               req_d;

    // Claim decode: one-hot of the id being taken this cycle.
    always_comb begin
        claim     = irq_valid & irq_ready;
        claim_hot = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            claim_hot[i] = claim && (irq_id == ID_W'(i));
        end
    end

    // Next pending vector and the candidate set for the output stage.
    // Only edge sources are masked after a claim: their pend bit still reads
    // set for the claim cycle, whereas a level source that remains asserted
    // is genuinely pending again and is re-presented back to back.
    always_comb begin
        edge_det = src_intr & ~src_q;
        pend_d   = cfg_en & ((cfg_edge & ((pend & ~claim_hot) | edge_det))
                           | (~cfg_edge & src_intr));
        cand     = pend & ~(claim_hot & cfg_edge);
    end

    wic_prio_enc #(
        .N  (NUM_SRC),
        .IW (ID_W)
    ) u_prio (
        .req   (cand),
        .found (cand_found),
        .idx   (cand_id)
    );

    // Source sampling, pending state and the held-until-claimed output stage.
    always_ff @(posedge pad_core_clk or negedge pad_core_rst_b) begin
        if (!pad_core_rst_b) begin
            src_q     <= '0;
            pend      <= '0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            src_q <= src_intr;
            pend  <= pend_d;
            if (!irq_valid || claim) begin
                irq_valid <= cand_found;
                irq_id    <= cand_id;
            end
        end
    end

    // Wakeup FSM next state; the request is derived from the next state so
    // the registered output is high exactly while the FSM sits in WAKE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!cpu_pmu_sleep_b) state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (cpu_pmu_sleep_b)  state_d = ST_RUN;
                else if (|pend)       state_d = ST_WAKE;
            end
            ST_WAKE: begin
                if (pmu_wic_wakeup_ack) state_d = ST_WAIT_RUN;
            end
            ST_WAIT_RUN: begin
                if (cpu_pmu_sleep_b) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        req_d = (state_d == ST_WAKE);
    end

    // Wakeup FSM state and registered, glitch-free wakeup request.
    always_ff @(posedge pad_core_clk or negedge pad_core_rst_b) begin
        if (!pad_core_rst_b) begin
            state_q            <= ST_RUN;
            wic_pmu_wakeup_req <= 1'b0;
        end else begin
            state_q            <= state_d;
            wic_pmu_wakeup_req <= req_d;
        end
    end

endmodule

// File: tb/tb_wic_irq_aggr.sv
// Scoreboard bench for wic_irq_aggr: directed stimulus pushes expected claim
// ids, forked monitors pop and compare on every valid&ready handshake, and
// cycle-exact checks cover latency, hold, pending state and wakeup handshake.
module tb_wic_irq_aggr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [31:0] src, en, edg, pend;
    logic        ready, sleep_b, ack, valid, req;
    logic [4:0]  id;

    logic [63:0] src64, en64, edg64, pend64;
    logic        ready64, sleep64, ack64, valid64, req64;
    logic [5:0]  id64;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int exp_q64[$];

    always #5 clk = ~clk;

    wic_irq_aggr #(.NUM_SRC(32), .ID_W(5)) dut (
        .pad_core_clk       (clk),
        .pad_core_rst_b     (rst_n),
        .src_intr           (src),
        .cfg_en             (en),
        .cfg_edge           (edg),
        .irq_valid          (valid),
        .irq_id             (id),
        .irq_ready          (ready),
        .cpu_pmu_sleep_b    (sleep_b),
        .wic_pmu_wakeup_req (req),
        .pmu_wic_wakeup_ack (ack),
        .pend               (pend)
    );

    wic_irq_aggr #(.NUM_SRC(64), .ID_W(6)) dut64 (
        .pad_core_clk       (clk),
        .pad_core_rst_b     (rst_n),
        .src_intr           (src64),
        .cfg_en             (en64),
        .cfg_edge           (edg64),
        .irq_valid          (valid64),
        .irq_id             (id64),
        .irq_ready          (ready64),
        .cpu_pmu_sleep_b    (sleep64),
        .wic_pmu_wakeup_req (req64),
        .pmu_wic_wakeup_ack (ack64),
        .pend               (pend64)
    );

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        src = '0; en = '0; edg = '0; ready = 1'b0; sleep_b = 1'b1; ack = 1'b0;
        src64 = '0; en64 = '0; edg64 = '0; ready64 = 1'b0; sleep64 = 1'b1; ack64 = 1'b0;

        fork
            begin : mon32
                forever begin
                    @(negedge clk);
                    if (valid === 1'b1 && ready === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL claim32_unexpected: got id %0d expected no claim at %0t", id, $time);
                        end else begin
                            chk("claim32_id", id, exp_q.pop_front());
                        end
                    end
                end
            end
            begin : mon64
                forever begin
                    @(negedge clk);
                    if (valid64 === 1'b1 && ready64 === 1'b1) begin
                        if (exp_q64.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL claim64_unexpected: got id %0d expected no claim at %0t", id64, $time);
                        end else begin
                            chk("claim64_id", id64, exp_q64.pop_front());
                        end
                    end
                end
            end
        join_none

        // Asynchronous reset takes effect before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_id", id, 0);
        chk("rst_pend", pend, 0);
        chk("rst_req", req, 0);
        chk("rst64_valid", valid64, 0);
        chk("rst64_pend", pend64, 0);
        tick(2);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", valid, 0);

        // Single edge pulse on source 3: pend at +1, valid/id at +2, claim clears.
        en[3] = 1'b1; edg[3] = 1'b1; src[3] = 1'b1;
        tick();
        src[3] = 1'b0;
        chk("t1_pend3_set", pend[3], 1);
        chk("t1_valid_early", valid, 0);
        tick();
        chk("t1_valid", valid, 1);
        chk("t1_id", id, 3);
        exp_q.push_back(3);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t1_pend3_clr", pend[3], 0);
        chk("t1_valid_clr", valid, 0);

        // Level 5 + edge 2, ready held: ids 2,5,5,5 back to back.
        en[5] = 1'b1; edg[5] = 1'b0; en[2] = 1'b1; edg[2] = 1'b1;
        src[5] = 1'b1; src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        chk("t2_pend", pend, 32'h24);
        tick();
        chk("t2_valid0", valid, 1);
        chk("t2_id0", id, 2);
        exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(5);
        ready = 1'b1;
        tick();
        chk("t2_valid1", valid, 1);
        tick();
        chk("t2_valid2", valid, 1);
        src[5] = 1'b0;
        tick();
        chk("t2_valid3", valid, 1);
        tick();
        chk("t2_valid_drop", valid, 0);
        chk("t2_pend_drop", pend, 0);
        ready = 1'b0;

        // Held presentation of id 7 while lower source 1 becomes pending.
        en[7] = 1'b1; edg[7] = 1'b1; en[1] = 1'b1; edg[1] = 1'b1;
        src[7] = 1'b1;
        tick();
        src[7] = 1'b0;
        tick();
        chk("t3_valid", valid, 1);
        chk("t3_id7", id, 7);
        src[1] = 1'b1;
        tick();
        src[1] = 1'b0;
        chk("t3_hold_id_a", id, 7);
        chk("t3_pend1", pend[1], 1);
        tick();
        chk("t3_hold_valid", valid, 1);
        chk("t3_hold_id_b", id, 7);
        exp_q.push_back(7); exp_q.push_back(1);
        ready = 1'b1;
        tick();
        chk("t3_next_id", id, 1);
        chk("t3_next_valid", valid, 1);
        tick();
        ready = 1'b0;
        chk("t3_done", valid, 0);

        // Edge on source 4 coincident with its claim: set wins, re-presented.
        en[4] = 1'b1; edg[4] = 1'b1; src[4] = 1'b1;
        tick();
        src[4] = 1'b0;
        tick();
        chk("t4_valid", valid, 1);
        chk("t4_id", id, 4);
        exp_q.push_back(4);
        ready = 1'b1; src[4] = 1'b1;
        tick();
        ready = 1'b0; src[4] = 1'b0;
        chk("t4_pend4_kept", pend[4], 1);
        chk("t4_gap", valid, 0);
        tick();
        chk("t4_re_valid", valid, 1);
        chk("t4_re_id", id, 4);
        exp_q.push_back(4);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t4_pend4_clr", pend[4], 0);
        chk("t4_valid_clr", valid, 0);

        // Disabling a source clears its pending bit on the next cycle.
        en[9] = 1'b1; edg[9] = 1'b0; src[9] = 1'b1;
        tick();
        chk("t5_pend9", pend[9], 1);
        en[9] = 1'b0;
        tick();
        chk("t5_pend9_dis", pend[9], 0);
        chk("t5_valid", valid, 1);
        chk("t5_id", id, 9);
        exp_q.push_back(9);
        ready = 1'b1;
        tick();
        ready = 1'b0; src[9] = 1'b0;
        chk("t5_valid_clr", valid, 0);

        // Wakeup handshake while the CPU sleeps; claim path stays live.
        en[0] = 1'b1; edg[0] = 1'b1;
        sleep_b = 1'b0;
        tick();
        chk("t6_req_sleep", req, 0);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        chk("t6_req_pend", req, 0);
        chk("t6_pend0", pend[0], 1);
        tick();
        chk("t6_req_a", req, 1);
        chk("t6_irq_valid", valid, 1);
        chk("t6_irq_id", id, 0);
        tick();
        chk("t6_req_b", req, 1);
        tick();
        chk("t6_req_c", req, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t6_req_ackd", req, 0);
        sleep_b = 1'b1;
        exp_q.push_back(0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t6_valid_clr", valid, 0);
        chk("t6_req_run", req, 0);
        sleep_b = 1'b0;
        tick();
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        tick();
        chk("t6_req_again", req, 1);

        // Reset mid-handshake drops the request without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("t7_req_async", req, 0);
        chk("t7_valid_async", valid, 0);
        chk("t7_pend_async", pend, 0);
        sleep_b = 1'b1;
        en[6] = 1'b1; edg[6] = 1'b1; src[6] = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t7_edge_at_release", pend[6], 1);
        tick();
        chk("t7_valid", valid, 1);
        chk("t7_id", id, 6);
        exp_q.push_back(6);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t7_valid_clr", valid, 0);
        chk("t7_pend_clr", pend, 0);
        src[6] = 1'b0;

        // 64-source instance: highest index, then disabled source is silent.
        en64[63] = 1'b1; edg64[63] = 1'b1; src64[63] = 1'b1;
        tick();
        src64[63] = 1'b0;
        tick();
        chk("t8_valid", valid64, 1);
        chk("t8_id63", id64, 63);
        exp_q64.push_back(63);
        ready64 = 1'b1;
        tick();
        ready64 = 1'b0;
        chk("t8_valid_clr", valid64, 0);
        en64[63] = 1'b0;
        sleep64 = 1'b0;
        tick();
        src64[63] = 1'b1;
        tick();
        src64[63] = 1'b0;
        chk("t8_pend_dis", pend64, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t8_no_valid", valid64, 0);
            chk("t8_no_req", req64, 0);
        end
        sleep64 = 1'b1;

        tick(2);
        chk("sb32_empty", exp_q.size(), 0);
        chk("sb64_empty", exp_q64.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wic_irq_aggr.md
WIC_IRQ_AGGR -- requirements
Module: wic_irq_aggr

Interface
REQ-001 Parameter NUM_SRC, default 32, meaning number of interrupt sources, legal range 2..64.
REQ-002 Parameter ID_W, default 5, meaning irq_id width, equal to clog2(NUM_SRC).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 pad_core_clk  in  1  sole clock.
REQ-005 pad_core_rst_b  in  1  reset: asynchronous assert, active-low.
REQ-006 src_intr  in  NUM_SRC  raw interrupt lines, synchronous to pad_core_clk.
REQ-007 cfg_en  in  NUM_SRC  per-source enable mask.
REQ-008 cfg_edge  in  NUM_SRC  per-source mode: 1 = rising-edge latched, 0 = level.
REQ-009 irq_valid  out  1  a claimable interrupt is presented.
REQ-010 irq_id  out  ID_W  index of the presented interrupt.
REQ-011 irq_ready  in  1  CPU claim; a claim occurs when irq_valid and irq_ready are both 1.
REQ-012 cpu_pmu_sleep_b  in  1  CPU sleep indication: 0 = sleeping.
REQ-013 wic_pmu_wakeup_req  out  1  wakeup request to the PMU.
REQ-014 pmu_wic_wakeup_ack  in  1  PMU wakeup acknowledge.
REQ-015 pend  out  NUM_SRC  current pending vector, for status and debug.

Function
REQ-016 Sample src_intr into a registered src_q every cycle; edge detect = src_intr & ~src_q.
REQ-017 Edge source i: pend[i] SHALL set on edge & cfg_en[i] and clear on a claim of id i; if both occur in the same cycle, set wins.
REQ-018 Level source i: pend[i] SHALL be registered src_intr[i] & cfg_en[i]; a claim has no effect on it.
REQ-019 Deasserting cfg_en[i] SHALL clear pend[i] on the next cycle.
REQ-020 Output stage: when irq_valid=0, or a claim occurs, load irq_valid = |pend and irq_id = lowest set index of pend, masking out the id just claimed.
REQ-021 While irq_valid=1 and irq_ready=0, irq_valid and irq_id SHALL hold stable, even if a lower-index source becomes pending.
REQ-022 Latency: edge at src_intr in cycle n -> pend set at n+1 -> irq_valid at n+2 (claimable at n+2).
REQ-023 Back-to-back claims SHALL be sustained at one per cycle when multiple sources are pending.
REQ-024 Wakeup FSM states are RUN, SLEEP, WAKE, WAIT_RUN.
REQ-025 RUN -> SLEEP when cpu_pmu_sleep_b=0.
REQ-026 SLEEP -> WAKE when |pend; SLEEP -> RUN when cpu_pmu_sleep_b=1.
REQ-027 WAKE: wic_pmu_wakeup_req=1, held until pmu_wic_wakeup_ack=1, then -> WAIT_RUN.
REQ-028 WAIT_RUN: wic_pmu_wakeup_req=0; -> RUN when cpu_pmu_sleep_b=1.
REQ-029 wic_pmu_wakeup_req SHALL be registered and glitch-free, asserted only in WAKE.
REQ-030 The claim path SHALL operate independently of FSM state.

Reset
REQ-031 On pad_core_rst_b=0, immediately: pend=0, src_q=0, irq_valid=0, irq_id=0, wic_pmu_wakeup_req=0, FSM=RUN.
REQ-032 src_q resets to 0, so a line high at reset release registers as an edge on the first clock.
REQ-033 Reset asserted mid-handshake SHALL drop wic_pmu_wakeup_req within the same cycle, asynchronously.

Structure
REQ-034 Shared package wic_pkg SHALL hold the FSM state enum (2-bit encoding) and the NUM_SRC default and legal range.
REQ-035 One sub-module, wic_prio_enc, SHALL be a parametrised lowest-index-first priority encoder producing a found flag and an index.

Verification
REQ-036 Edge source 3 enabled, pulse src_intr[3] for 1 cycle at cycle 10 -> irq_valid=1 and irq_id=3 at cycle 12; claim -> pend[3]=0 and irq_valid=0 next cycle.
REQ-037 Sources 5 (level) and 2 (edge) pending, irq_ready held 1 -> ids 2, 5, 5, ... on consecutive cycles while src 5 stays high; drop src 5 -> irq_valid=0 within 2 cycles.
REQ-038 irq_valid=1 with id 7 and irq_ready=0, then source 1 fires -> irq_id stays 7 until claimed, then becomes 1.
REQ-039 Edge on source 4 in the same cycle as a claim of id 4 -> pend[4] remains 1 and id 4 is re-presented.
REQ-040 cpu_pmu_sleep_b=0, source 0 fires -> wic_pmu_wakeup_req=1 until ack; ack at +3 -> req=0 next cycle; sleep_b=1 -> FSM returns to RUN.
REQ-041 NUM_SRC=64: source 63 only -> irq_id=63; cfg_en[63]=0 -> no irq_valid and no wakeup request.
